// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, data-memory freeze, IF squash/bubble.
// Optional stall-cycle performance counter is built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  RsIfId,
  input  logic [2:0]  RtIfId,
  input  logic        RsValidIfId,
  input  logic        RtValidIfId,
  input  logic [2:0]  writeRegIdEx,
  input  logic        writeRegValidIdEx,
  input  logic        MemReadIdEx,
  input  logic        branchTakenEx,
  input  logic        dmemStall,
  input  logic        imemStall,
  output logic        stallPc,
  output logic        stallIfId,
  output logic        flushIfId,
  output logic        bubbleIdEx,
  output logic        freezeAll,
  output logic        err,
  output logic [1:0]  state,
  output logic [15:0] stallCycles
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDUSE   = 2'b01,
    MEMWAIT = 2'b10,
    ERR     = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;
  logic       load_use;
  logic       stall_pc_c, stall_ifid_c, flush_ifid_c, bubble_idex_c, freeze_c;

  always_comb begin
    load_use = MemReadIdEx & writeRegValidIdEx &
               ((RsValidIfId & (RsIfId == writeRegIdEx)) |
                (RtValidIfId & (RtIfId == writeRegIdEx)));

    // NOTE: every signal gets a default here so no path through the case leaves one unassigned (no latches).
    state_d       = state_q;
    wait_d        = wait_q;
    err_d         = err_q;
    stall_pc_c    = 1'b0;
    stall_ifid_c  = 1'b0;
    flush_ifid_c  = 1'b0;
    bubble_idex_c = 1'b0;
    freeze_c      = 1'b0;

    if (state_q == ERR) begin
      stall_pc_c   = 1'b1;
      stall_ifid_c = 1'b1;
      freeze_c     = 1'b1;
      wait_d       = 8'd0;
    end else if (dmemStall) begin
      // A concurrent branch is dropped: EX is frozen and will present it again.
      stall_pc_c   = 1'b1;
      stall_ifid_c = 1'b1;
      freeze_c     = 1'b1;
      if (state_q == MEMWAIT) begin
        wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
        if (wait_q >= TIMEOUT) begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end else begin
        state_d = MEMWAIT;
        wait_d  = 8'd1;
      end
    end else begin
      wait_d  = 8'd0;
      state_d = RUN;
      if (branchTakenEx) begin
        flush_ifid_c  = 1'b1;
        bubble_idex_c = 1'b1;
      end else if (load_use && state_q != LDUSE) begin
        stall_pc_c    = 1'b1;
        stall_ifid_c  = 1'b1;
        bubble_idex_c = 1'b1;
        state_d       = LDUSE;
      end else if (imemStall) begin
        stall_pc_c   = 1'b1;
        flush_ifid_c = 1'b1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign stallPc    = stall_pc_c    & ~rst;
  assign stallIfId  = stall_ifid_c  & ~rst;
  assign flushIfId  = flush_ifid_c  & ~rst;
  assign bubbleIdEx = bubble_idex_c & ~rst;
  assign freezeAll  = freeze_c      & ~rst;
  assign err        = err_q;
  assign state      = state_q;

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_pc_c && state_q != ERR && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= 16'h0000;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stallCycles = stall_cnt_q;
`else
  assign stallCycles = 16'h0000;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage core; pairs with the EX-stage forwarding unit, covering the cases forwarding cannot. Detects load-use hazards between ID and EX, freezes the pipe while data memory is busy, bubbles IF/ID on instruction-memory stalls and squashes on taken branches. A small state machine tracks bubble and memory-wait phases and traps runaway memory waits.

## Interface
- TIMEOUT, 64: max consecutive MEMWAIT cycles before ERR (8-bit compare).

- clk  in  1  core clock; all state rises on posedge.
- rst  in  1  asynchronous, active-high reset.
- RsIfId, RtIfId  in  3  source regs of the instruction in ID.
- RsValidIfId, RtValidIfId  in  1  source actually read.
- writeRegIdEx  in  3  dest reg of the instruction in EX.
- writeRegValidIdEx  in  1  dest valid.
- MemReadIdEx  in  1  instruction in EX is a load.
- branchTakenEx  in  1  taken branch/jump resolved in EX.
- dmemStall  in  1  data memory not ready this cycle.
- imemStall  in  1  instruction memory not ready this cycle.
- stallPc  out  1  hold PC.
- stallIfId  out  1  hold IF/ID.
- flushIfId  out  1  load NOP into IF/ID.
- bubbleIdEx  out  1  load NOP into ID/EX.
- freezeAll  out  1  hold ID/EX, EX/MEM, MEM/WB.
- err  out  1  sticky memory-timeout error.
- state  out  2  RUN=00, LDUSE=01, MEMWAIT=10, ERR=11.
- stallCycles  out  16  stall-cycle counter (see Configuration).

## Operation
- Control outputs are combinational from registered state plus inputs; state, wait counter, stallCycles and err are registered.
- loadUse = MemReadIdEx & writeRegValidIdEx & ((RsValidIfId & RsIfId==writeRegIdEx) | (RtValidIfId & RtIfId==writeRegIdEx)).
- RUN, priority highest first:
  - dmemStall: stallPc=stallIfId=freezeAll=1; next MEMWAIT, wait counter := 1.
  - branchTakenEx: flushIfId=bubbleIdEx=1, stallPc=0, even if imemStall or loadUse; next RUN.
  - loadUse: stallPc=stallIfId=bubbleIdEx=1; next LDUSE.
  - imemStall: stallPc=flushIfId=1; next RUN.
  - else all controls 0.
- LDUSE (exactly one cycle): load-use detection suppressed. dmemStall -> MEMWAIT as in RUN. branchTakenEx/imemStall handled as in RUN. Otherwise -> RUN, no stall.
- MEMWAIT: stallPc=stallIfId=freezeAll=1 while dmemStall. Counter increments each cycle. dmemStall low -> controls released that same cycle and evaluated as in RUN; next state per RUN rules. Counter reaching TIMEOUT with dmemStall still high -> ERR.
- ERR: err=1, stallPc=stallIfId=freezeAll=1 permanently. Only rst exits.
- A branch concurrent with dmemStall is ignored; EX is frozen, so the branch is re-presented after release.

## Timing
- Reset (async assert, sync-safe deassert): state=RUN, counters=0, err=0. While rst is high, all control outputs are forced 0.
- Load-use costs exactly 1 bubble: the hazard cycle stalls, and the next cycle (LDUSE) proceeds. The forwarding unit supplies MEM/WB load data.
- Branch squash is 2 instructions, same cycle as branchTakenEx; no state change.
- MEMWAIT adds no cycles beyond dmemStall.
- Wait counter is 8 bits and does not wrap; it is cleared on MEMWAIT exit.
- rst during MEMWAIT or ERR returns to RUN immediately.

## Configuration
- HAZARD_PERF_EN defined:
  - stallCycles increments on every cycle with stallPc=1 while not in ERR.
  - Saturates at 16'hFFFF.
  - Cleared by rst.
- HAZARD_PERF_EN undefined: stallCycles tied to 16'h0000, and no counter flops exist.

## Test plan
- Load r3 in EX, ID reads Rs=r3 valid -> 1 cycle stallPc=stallIfId=bubbleIdEx=1, state 01 next, then 00 with no stall.
- Load r3 in EX, ID reads Rt=r3 with RtValidIfId=0 -> no stall, state stays 00.
- dmemStall high 5 cycles -> freezeAll=1 for exactly 5 cycles, state 10 for 5 cycles. With HAZARD_PERF_EN, stallCycles=5.
- branchTakenEx=1 with loadUse=1 and imemStall=1 same cycle -> flushIfId=bubbleIdEx=1, stallPc=0, state 00.
- dmemStall held 70 cycles, TIMEOUT=64 -> state 11 and err=1 after 64 MEMWAIT cycles; err stays 1 after dmemStall drops; rst clears it to 0.
- rst asserted mid-MEMWAIT -> state 00, all controls 0 immediately, stallCycles=0.
